// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Purpose:
//   Shares the single port of the unified byte-addressable data memory
//   between the instruction-fetch unit (i_*) and the load/store unit (d_*).
//   A winning request is granted in IDLE, its command is latched, and the
//   command is driven on m_* for one access cycle. Loads and fetches then
//   spend one response cycle collecting m_rd. Stores finish in the access
//   cycle.
//
// Configuration macro:
//   MEM_ARB_ROUND_ROBIN_EN - when defined, simultaneous requests alternate
//   between the two ports using a 1-bit "last owner" history register.
//   When undefined, arbitration is fixed priority and the data port wins.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   i_req, i_addr               fetch request and byte address (low 2 bits ignored)
//   i_gnt, i_done, i_rdata      fetch accept pulse, data-valid pulse, fetched word
//   d_req, d_we, d_size,        load/store request and command fields
//   d_signed, d_addr, d_wdata
//   d_gnt, d_done, d_rdata      load/store accept pulse, completion pulse, load data
//   m_we, m_size, m_signed,     memory command outputs
//   m_addr, m_wd
//   m_rd                        memory read data, valid the cycle after m_addr

module mem_arbiter #(
  parameter int SIZE_LOG2 = 13
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 i_req,
  input  logic [SIZE_LOG2-1:0] i_addr,
  output logic                 i_gnt,
  output logic                 i_done,
  output logic [31:0]          i_rdata,

  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [1:0]           d_size,
  input  logic                 d_signed,
  input  logic [SIZE_LOG2-1:0] d_addr,
  input  logic [31:0]          d_wdata,
  output logic                 d_gnt,
  output logic                 d_done,
  output logic [31:0]          d_rdata,

  output logic                 m_we,
  output logic [1:0]           m_size,
  output logic                 m_signed,
  output logic [SIZE_LOG2-1:0] m_addr,
  output logic [31:0]          m_wd,
  input  logic [31:0]          m_rd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } stateT;

  // Clears the two low address bits so every fetch is word aligned.
  localparam logic [SIZE_LOG2-1:0] WORD_MASK = ~(SIZE_LOG2'(3));

  stateT state;
  stateT nextState;

  logic                 grantData;
  logic                 grantFetch;

  logic                 cmdWe;
  logic [1:0]           cmdSize;
  logic                 cmdSigned;
  logic [SIZE_LOG2-1:0] cmdAddr;
  logic [31:0]          cmdWd;
  logic                 cmdData;

  logic [31:0]          iRdataReg;
  logic [31:0]          dRdataReg;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic lastData;

  // History of the most recent winner; reset to "fetch last" so the data
  // port takes the first tie after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastData <= 1'b0;
    end else if (grantData || grantFetch) begin
      lastData <= grantData;
    end
  end

  // On a tie the port that lost last time wins; a lone request always wins.
  always_comb begin
    grantData  = 1'b0;
    grantFetch = 1'b0;
    if (state == IDLE && !rst) begin
      if (d_req && i_req) begin
        grantData  = !lastData;
        grantFetch = lastData;
      end else begin
        grantData  = d_req;
        grantFetch = i_req;
      end
    end
  end
`else
  // Fixed priority: the data port always beats the fetch port.
  always_comb begin
    grantData  = 1'b0;
    grantFetch = 1'b0;
    if (state == IDLE && !rst) begin
      grantData  = d_req;
      grantFetch = i_req && !d_req;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: stores finish after the access cycle, reads need
  // one more cycle to collect the memory's registered read data.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (grantData || grantFetch) begin
          nextState = ACCESS;
        end
      end
      ACCESS: begin
        nextState = cmdWe ? IDLE : RESP;
      end
      RESP: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Command register, loaded in the grant cycle from the winning port.
  // Fetches are always aligned, unsigned word reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmdWe     <= 1'b0;
      cmdSize   <= 2'b00;
      cmdSigned <= 1'b0;
      cmdAddr   <= '0;
      cmdWd     <= 32'h0;
      cmdData   <= 1'b0;
    end else if (grantData) begin
      cmdWe     <= d_we;
      cmdSize   <= d_size;
      cmdSigned <= d_signed;
      cmdAddr   <= d_addr;
      cmdWd     <= d_wdata;
      cmdData   <= 1'b1;
    end else if (grantFetch) begin
      cmdWe     <= 1'b0;
      cmdSize   <= 2'b10;
      cmdSigned <= 1'b0;
      cmdAddr   <= i_addr & WORD_MASK;
      cmdWd     <= 32'h0;
      cmdData   <= 1'b0;
    end
  end

  // Read-data holding registers; each keeps the owner's last result until
  // that owner's next read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      iRdataReg <= 32'h0;
      dRdataReg <= 32'h0;
    end else if (state == RESP) begin
      if (cmdData) begin
        dRdataReg <= m_rd;
      end else begin
        iRdataReg <= m_rd;
      end
    end
  end

  // Output decode. The latched command is presented in both ACCESS and RESP
  // so the address stays stable while the memory returns data. In RESP the
  // rdata outputs bypass m_rd so data and done appear in the same cycle.
  // Reset suppresses write enable, done pulses and the bypass immediately.
  always_comb begin
    i_gnt    = grantFetch;
    d_gnt    = grantData;
    i_done   = 1'b0;
    d_done   = 1'b0;
    m_we     = 1'b0;
    m_size   = 2'b00;
    m_signed = 1'b0;
    m_addr   = '0;
    m_wd     = 32'h0;
    i_rdata  = iRdataReg;
    d_rdata  = dRdataReg;
    case (state)
      ACCESS: begin
        m_we     = cmdWe && !rst;
        m_size   = cmdSize;
        m_signed = cmdSigned;
        m_addr   = cmdAddr;
        m_wd     = cmdWd;
        d_done   = cmdWe && cmdData && !rst;
      end
      RESP: begin
        m_size   = cmdSize;
        m_signed = cmdSigned;
        m_addr   = cmdAddr;
        m_wd     = cmdWd;
        if (!rst) begin
          if (cmdData) begin
            d_done  = 1'b1;
            d_rdata = m_rd;
          end else begin
            i_done  = 1'b1;
            i_rdata = m_rd;
          end
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//
// Directed testbench for mem_arbiter. Contains a byte-addressable memory
// model with registered read data (valid the cycle after the address) and
// little-endian sized, optionally sign-extended reads. Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.

module tb_mem_arbiter;

  localparam int SIZE_LOG2 = 13;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_req;
  logic [SIZE_LOG2-1:0] i_addr;
  logic                 i_gnt;
  logic                 i_done;
  logic [31:0]          i_rdata;
  logic                 d_req;
  logic                 d_we;
  logic [1:0]           d_size;
  logic                 d_signed;
  logic [SIZE_LOG2-1:0] d_addr;
  logic [31:0]          d_wdata;
  logic                 d_gnt;
  logic                 d_done;
  logic [31:0]          d_rdata;
  logic                 m_we;
  logic [1:0]           m_size;
  logic                 m_signed;
  logic [SIZE_LOG2-1:0] m_addr;
  logic [31:0]          m_wd;
  logic [31:0]          m_rd;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.SIZE_LOG2(SIZE_LOG2)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_done   (i_done),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_size   (d_size),
    .d_signed (d_signed),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .m_we     (m_we),
    .m_size   (m_size),
    .m_signed (m_signed),
    .m_addr   (m_addr),
    .m_wd     (m_wd),
    .m_rd     (m_rd)
  );

  always #5 clk = ~clk;

  // Memory model storage and registered read port.
  logic [7:0] mem [0:(1<<SIZE_LOG2)-1];

  function automatic logic [31:0] memRead(input logic [SIZE_LOG2-1:0] a,
                                          input logic [1:0] sz, input logic sg);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[a];
    b1 = mem[a + 13'd1];
    b2 = mem[a + 13'd2];
    b3 = mem[a + 13'd3];
    case (sz)
      2'b00:   return sg ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'b01:   return sg ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  always @(posedge clk) begin
    if (m_we) begin
      mem[m_addr] <= m_wd[7:0];
      if (m_size != 2'b00) begin
        mem[m_addr + 13'd1] <= m_wd[15:8];
      end
      if (m_size != 2'b00 && m_size != 2'b01) begin
        mem[m_addr + 13'd2] <= m_wd[23:16];
        mem[m_addr + 13'd3] <= m_wd[31:24];
      end
    end
    m_rd <= memRead(m_addr, m_size, m_signed);
  end

  // Issues one load/store on the data port and reports grant wait, done
  // latency counted from the grant cycle, load data, and the m_* command
  // seen in the cycle after grant. -1 marks an expired wait.
  task automatic dataAccess(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [SIZE_LOG2-1:0] addr, input logic [31:0] wdata,
                            output int gntWait, output int doneLat, output logic [31:0] rdata,
                            output logic accWe, output logic [SIZE_LOG2-1:0] accAddr,
                            output logic [1:0] accSize);
    gntWait = -1;
    doneLat = -1;
    rdata   = 32'h0;
    accWe   = 1'b0;
    accAddr = '0;
    accSize = 2'b00;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_size = size; d_signed = sgn; d_addr = addr; d_wdata = wdata;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_gnt === 1'b1) begin
        gntWait = k;
        break;
      end
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    if (gntWait >= 0) begin
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (k == 1) begin
          accWe = m_we; accAddr = m_addr; accSize = m_size;
        end
        if (d_done === 1'b1) begin
          doneLat = k;
          rdata   = d_rdata;
          break;
        end
      end
    end
  endtask

  // Same as dataAccess for the fetch port; also reports any d_done seen.
  task automatic fetchAccess(input logic [SIZE_LOG2-1:0] addr,
                             output int gntWait, output int doneLat, output logic [31:0] rdata,
                             output logic [SIZE_LOG2-1:0] accAddr, output logic [1:0] accSize,
                             output logic sawDDone);
    gntWait  = -1;
    doneLat  = -1;
    rdata    = 32'h0;
    accAddr  = '0;
    accSize  = 2'b00;
    sawDDone = 1'b0;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = addr;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_done === 1'b1) sawDDone = 1'b1;
      if (i_gnt === 1'b1) begin
        gntWait = k;
        break;
      end
    end
    @(posedge clk); #1;
    i_req = 1'b0;
    if (gntWait >= 0) begin
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (d_done === 1'b1) sawDDone = 1'b1;
        if (k == 1) begin
          accAddr = m_addr; accSize = m_size;
        end
        if (i_done === 1'b1) begin
          doneLat = k;
          rdata   = i_rdata;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (i_gnt !== 1'b0)    begin bad++; $display("[TB] FAIL reset_i_gnt got=%b want=0", i_gnt); end
    total++; if (d_gnt !== 1'b0)    begin bad++; $display("[TB] FAIL reset_d_gnt got=%b want=0", d_gnt); end
    total++; if (i_done !== 1'b0)   begin bad++; $display("[TB] FAIL reset_i_done got=%b want=0", i_done); end
    total++; if (d_done !== 1'b0)   begin bad++; $display("[TB] FAIL reset_d_done got=%b want=0", d_done); end
    total++; if (m_we !== 1'b0)     begin bad++; $display("[TB] FAIL reset_m_we got=%b want=0", m_we); end
    total++; if ({m_size, m_signed, m_addr, m_wd} !== '0)
      begin bad++; $display("[TB] FAIL reset_m_cmd got=%h/%b/%h/%h want=0", m_size, m_signed, m_addr, m_wd); end
    total++; if (i_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_i_rdata got=%h want=0", i_rdata); end
    total++; if (d_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_d_rdata got=%h want=0", d_rdata); end
  endtask

  task automatic test_store_load_word();
    int gw, lat;
    logic [31:0] rd;
    logic aWe;
    logic [SIZE_LOG2-1:0] aAddr;
    logic [1:0] aSize;
    dataAccess(1'b1, 2'b10, 1'b0, 13'h010, 32'hDEADBEEF, gw, lat, rd, aWe, aAddr, aSize);
    total++; if (gw != 0)  begin bad++; $display("[TB] FAIL store_gnt_wait got=%0d want=0", gw); end
    total++; if (lat != 1) begin bad++; $display("[TB] FAIL store_done_lat got=%0d want=1", lat); end
    total++; if (aWe !== 1'b1 || aAddr !== 13'h010)
      begin bad++; $display("[TB] FAIL store_m_cmd got we=%b addr=%h want we=1 addr=010", aWe, aAddr); end
    dataAccess(1'b0, 2'b10, 1'b0, 13'h010, 32'h0, gw, lat, rd, aWe, aAddr, aSize);
    total++; if (gw != 0)  begin bad++; $display("[TB] FAIL b2b_load_gnt_wait got=%0d want=0", gw); end
    total++; if (lat != 2) begin bad++; $display("[TB] FAIL load_done_lat got=%0d want=2", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL load_word got=%h want=deadbeef", rd); end
    @(negedge clk);
    total++; if (d_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL d_rdata_hold got=%h want=deadbeef", d_rdata); end
  endtask

  task automatic test_fetch();
    int gw, lat;
    logic [31:0] rd;
    logic aWe, sawD;
    logic [SIZE_LOG2-1:0] aAddr;
    logic [1:0] aSize;
    dataAccess(1'b1, 2'b10, 1'b0, 13'h010, 32'h12345678, gw, lat, rd, aWe, aAddr, aSize);
    fetchAccess(13'h013, gw, lat, rd, aAddr, aSize, sawD);
    total++; if (gw != 0)  begin bad++; $display("[TB] FAIL fetch_gnt_wait got=%0d want=0", gw); end
    total++; if (aAddr !== 13'h010) begin bad++; $display("[TB] FAIL fetch_m_addr got=%h want=010", aAddr); end
    total++; if (aSize !== 2'b10)   begin bad++; $display("[TB] FAIL fetch_m_size got=%b want=10", aSize); end
    total++; if (lat != 2) begin bad++; $display("[TB] FAIL fetch_done_lat got=%0d want=2", lat); end
    total++; if (rd !== 32'h12345678) begin bad++; $display("[TB] FAIL fetch_rdata got=%h want=12345678", rd); end
    total++; if (sawD !== 1'b0) begin bad++; $display("[TB] FAIL fetch_d_done got=%b want=0", sawD); end
  endtask

  task automatic test_byte_signed();
    int gw, lat;
    logic [31:0] rd;
    logic aWe;
    logic [SIZE_LOG2-1:0] aAddr;
    logic [1:0] aSize;
    dataAccess(1'b1, 2'b00, 1'b0, 13'h021, 32'h00000080, gw, lat, rd, aWe, aAddr, aSize);
    total++; if (lat != 1) begin bad++; $display("[TB] FAIL byte_store_lat got=%0d want=1", lat); end
    dataAccess(1'b0, 2'b00, 1'b1, 13'h021, 32'h0, gw, lat, rd, aWe, aAddr, aSize);
    total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("[TB] FAIL load_byte_signed got=%h want=ffffff80", rd); end
    dataAccess(1'b0, 2'b00, 1'b0, 13'h021, 32'h0, gw, lat, rd, aWe, aAddr, aSize);
    total++; if (rd !== 32'h00000080) begin bad++; $display("[TB] FAIL load_byte_unsigned got=%h want=00000080", rd); end
  endtask

  task automatic test_arbitration();
    logic [3:0] order;
    logic [3:0] expOrder;
    logic both;
    int n;
    order = 4'b0000;
    both  = 1'b0;
    n     = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    expOrder = 4'b0101;
`else
    expOrder = 4'b1111;
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_signed = 1'b0; d_addr = 13'h010;
    i_req = 1'b1; i_addr = 13'h000;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk);
      if (d_gnt === 1'b1 && i_gnt === 1'b1) both = 1'b1;
      if (d_gnt === 1'b1) begin order[n] = 1'b1; n++; end
      else if (i_gnt === 1'b1) begin order[n] = 1'b0; n++; end
    end
    @(posedge clk); #1;
    d_req = 1'b0; i_req = 1'b0;
    repeat (4) @(posedge clk);
    total++; if (n != 4) begin bad++; $display("[TB] FAIL arb_grant_count got=%0d want=4", n); end
    total++; if (order !== expOrder) begin bad++; $display("[TB] FAIL arb_order got=%b want=%b (bit0 first, 1=D)", order, expOrder); end
    total++; if (both !== 1'b0) begin bad++; $display("[TB] FAIL arb_dual_gnt got=%b want=0", both); end
  endtask

  task automatic test_reset_in_access();
    int gw, lat;
    logic [31:0] rd;
    logic aWe, sawGnt;
    logic [SIZE_LOG2-1:0] aAddr;
    logic [1:0] aSize;
    dataAccess(1'b1, 2'b10, 1'b0, 13'h040, 32'h11111111, gw, lat, rd, aWe, aAddr, aSize);
    dataAccess(1'b0, 2'b10, 1'b0, 13'h040, 32'h0, gw, lat, rd, aWe, aAddr, aSize);
    total++; if (rd !== 32'h11111111) begin bad++; $display("[TB] FAIL old_value got=%h want=11111111", rd); end
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_signed = 1'b0; d_addr = 13'h040; d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    sawGnt = d_gnt;
    total++; if (sawGnt !== 1'b1) begin bad++; $display("[TB] FAIL rst_acc_gnt got=%b want=1", sawGnt); end
    @(posedge clk); #1;
    d_req = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    total++; if (m_we !== 1'b0)   begin bad++; $display("[TB] FAIL rst_acc_m_we got=%b want=0", m_we); end
    total++; if (d_done !== 1'b0) begin bad++; $display("[TB] FAIL rst_acc_d_done got=%b want=0", d_done); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if ({i_gnt, d_gnt, i_done, d_done, m_we, m_size, m_signed} !== '0)
      begin bad++; $display("[TB] FAIL post_rst_ctrl got=%b want=0", {i_gnt, d_gnt, i_done, d_done, m_we, m_size, m_signed}); end
    total++; if (m_addr !== '0 || m_wd !== 32'h0)
      begin bad++; $display("[TB] FAIL post_rst_m got=%h/%h want=0/0", m_addr, m_wd); end
    total++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0)
      begin bad++; $display("[TB] FAIL post_rst_rdata got=%h/%h want=0/0", i_rdata, d_rdata); end
    dataAccess(1'b0, 2'b10, 1'b0, 13'h040, 32'h0, gw, lat, rd, aWe, aAddr, aSize);
    total++; if (rd !== 32'h11111111) begin bad++; $display("[TB] FAIL store_discarded got=%h want=11111111", rd); end
  endtask

  task automatic test_reset_in_resp();
    int gnted;
    gnted = 0;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_signed = 1'b0; d_addr = 13'h040;
    @(negedge clk);
    if (d_gnt === 1'b1) gnted = 1;
    total++; if (gnted != 1) begin bad++; $display("[TB] FAIL rst_resp_gnt got=%0d want=1", gnted); end
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (d_done !== 1'b0) begin bad++; $display("[TB] FAIL rst_resp_d_done got=%b want=0", d_done); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (d_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_resp_rdata got=%h want=0", d_rdata); end
  endtask

  initial begin
    rst = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_signed = 1'b0; d_addr = '0; d_wdata = 32'h0;
    test_reset();
    test_store_load_word();
    test_fetch();
    test_byte_signed();
    test_arbitration();
    test_reset_in_access();
    test_reset_in_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
